squeeze_ctrl: RTL and testbench

- Sequences the SHAKE squeeze phase after absorb completes.
- Hands each rate block of the Keccak state to the output buffer / dump logic and tracks how many output words remain.
- Requests a further Keccak-f permutation whenever more output is needed.
- Sits between the permutation core and the output buffer; the buffer's write-enable and block word count come from this block.

---
 rtl/squeeze_ctrl_if.sv | 25 ++
 rtl/squeeze_ctrl.sv | 98 +++++++++
 tb/tb_squeeze_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/squeeze_ctrl_if.sv
// Handshake bundle between the SHAKE squeeze controller, the permutation core and the output buffer.
interface squeeze_ctrl_if #(
    parameter int LEN_W = 32,
    parameter int CNT_W = 5
);
    logic             start;
    logic [LEN_W-1:0] output_len_words;
    logic             perm_start;
    logic             perm_done;
    logic             output_buffer_available_wr;
    logic             output_buffer_we;
    logic [CNT_W-1:0] block_words;
    logic             busy;
    logic             done;

    modport master (
        output start, output_len_words, perm_done, output_buffer_available_wr,
        input  perm_start, output_buffer_we, block_words, busy, done
    );

    modport slave (
        input  start, output_len_words, perm_done, output_buffer_available_wr,
        output perm_start, output_buffer_we, block_words, busy, done
    );
endinterface

// File: rtl/squeeze_ctrl.sv
// SHAKE squeeze sequencer: hands rate blocks to the output buffer and requests
// further Keccak-f permutations until the requested number of words has been emitted.
module squeeze_ctrl #(
    parameter int RATE_WORDS = 17,
    parameter int LEN_W      = 32,
    parameter int CNT_W      = 5
) (
    input logic           clk,
    input logic           rst_n,
    squeeze_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        LOAD,
        PERM_REQ,
        PERM_WAIT,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] RATE_LEN = LEN_W'(RATE_WORDS);
    localparam logic [CNT_W-1:0] RATE_CNT = CNT_W'(RATE_WORDS);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] next_block;

    always_comb begin
        next_block = (remaining < RATE_LEN) ? remaining[CNT_W-1:0] : RATE_CNT;
    end

    // Outputs are registered alongside the state transition, so each one is
    // asserted exactly while the FSM sits in the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            remaining            <= '0;
            bus.perm_start       <= 1'b0;
            bus.output_buffer_we <= 1'b0;
            bus.block_words      <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
        end else begin
            bus.perm_start       <= 1'b0;
            bus.output_buffer_we <= 1'b0;
            bus.block_words      <= '0;
            bus.done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining <= bus.output_len_words;
                        bus.busy  <= 1'b1;
                        if (bus.output_len_words == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= WAIT_BUF;
                        end
                    end
                end
                WAIT_BUF: begin
                    if (bus.output_buffer_available_wr) begin
                        state                <= LOAD;
                        bus.output_buffer_we <= 1'b1;
                        bus.block_words      <= next_block;
                    end
                end
                LOAD: begin
                    // remaining <= RATE_LEN here is the same test as "new remaining == 0"
                    remaining <= remaining - LEN_W'(bus.block_words);
                    if (remaining <= RATE_LEN) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state          <= PERM_REQ;
                        bus.perm_start <= 1'b1;
                    end
                end
                PERM_REQ: begin
                    state <= PERM_WAIT;
                end
                PERM_WAIT: begin
                    if (bus.perm_done) begin
                        state <= WAIT_BUF;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_squeeze_ctrl.sv
// Directed self-checking bench for squeeze_ctrl with a fixed-latency permutation responder.
module tb_squeeze_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    squeeze_ctrl_if #(.LEN_W(32), .CNT_W(5)) bus ();

    squeeze_ctrl #(.RATE_WORDS(17), .LEN_W(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic perm_done_resp  = 1'b0;
    logic perm_done_stray = 1'b0;
    logic resp_en         = 1'b1;
    assign bus.perm_done = perm_done_resp | perm_done_stray;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         we_cnt   = 0;
    int         perm_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [4:0] bw_q[$];
    int         we_cyc_q[$];

    always @(negedge clk) begin
        if (bus.output_buffer_we === 1'b1) begin
            we_cnt++;
            bw_q.push_back(bus.block_words);
            we_cyc_q.push_back(cyc);
        end
        if (bus.perm_start === 1'b1) perm_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Core model: perm_done pulses 24 cycles after perm_start is seen.
    always begin
        @(negedge clk);
        if (resp_en && bus.perm_start === 1'b1) begin
            repeat (23) @(negedge clk);
            perm_done_resp = 1'b1;
            @(negedge clk);
            perm_done_resp = 1'b0;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len, output int s_cyc);
        bus.output_len_words = len;
        bus.start = 1'b1;
        s_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (done_cnt != base) break;
            tick();
        end
        checks++;
        if (done_cnt == base) begin
            fails++;
            $display("FAIL %s_timeout: done count %0d, required > %0d", name, done_cnt, base);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.perm_start !== 1'b0) begin fails++; $display("FAIL reset_perm_start: got %b want 0", bus.perm_start); end
        checks++; if (bus.output_buffer_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.output_buffer_we); end
        checks++; if (bus.block_words !== 5'd0) begin fails++; $display("FAIL reset_block_words: got %0d want 0", bus.block_words); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        int s, b_we, b_pm, b_dn;
        b_we = we_cnt; b_pm = perm_cnt; b_dn = done_cnt;
        bus.output_buffer_available_wr = 1'b1;
        start_run(5, s);
        wait_done(b_dn, 50, "single");
        tick();
        checks++; if (we_cnt - b_we !== 1) begin fails++; $display("FAIL single_we_count: got %0d want 1", we_cnt - b_we); end
        checks++; if (bw_q[b_we] !== 5'd5) begin fails++; $display("FAIL single_block_words: got %0d want 5", bw_q[b_we]); end
        checks++; if (we_cyc_q[b_we] - s !== 2) begin fails++; $display("FAIL single_we_latency: got %0d want 2", we_cyc_q[b_we] - s); end
        checks++; if (done_cyc - s !== 3) begin fails++; $display("FAIL single_done_latency: got %0d want 3", done_cyc - s); end
        checks++; if (perm_cnt - b_pm !== 0) begin fails++; $display("FAIL single_perm_count: got %0d want 0", perm_cnt - b_pm); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_multi_block();
        int s, b_we, b_pm, b_dn;
        int exp_bw[3] = '{17, 17, 6};
        b_we = we_cnt; b_pm = perm_cnt; b_dn = done_cnt;
        start_run(40, s);
        for (int i = 0; i < 100 && perm_cnt == b_pm; i++) tick();
        // a second start while busy must not disturb remaining
        bus.output_len_words = 3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(b_dn, 200, "multi");
        tick();
        checks++; if (we_cnt - b_we !== 3) begin fails++; $display("FAIL multi_we_count: got %0d want 3", we_cnt - b_we); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bw_q[b_we + i] !== 5'(exp_bw[i])) begin
                fails++; $display("FAIL multi_block_words[%0d]: got %0d want %0d", i, bw_q[b_we + i], exp_bw[i]);
            end
        end
        checks++; if (perm_cnt - b_pm !== 2) begin fails++; $display("FAIL multi_perm_count: got %0d want 2", perm_cnt - b_pm); end
        checks++; if (done_cnt - b_dn !== 1) begin fails++; $display("FAIL multi_done_count: got %0d want 1", done_cnt - b_dn); end
        checks++; if (done_cyc - we_cyc_q[b_we + 2] !== 1) begin fails++; $display("FAIL multi_done_after_last: got %0d want 1", done_cyc - we_cyc_q[b_we + 2]); end
    endtask

    task automatic test_exact_multiple();
        int s, b_we, b_pm, b_dn;
        int lens[2]  = '{17, 34};
        int loads[2] = '{1, 2};
        for (int k = 0; k < 2; k++) begin
            b_we = we_cnt; b_pm = perm_cnt; b_dn = done_cnt;
            start_run(lens[k], s);
            wait_done(b_dn, 100, "exact");
            repeat (30) tick();
            checks++; if (we_cnt - b_we !== loads[k]) begin fails++; $display("FAIL exact%0d_we_count: got %0d want %0d", lens[k], we_cnt - b_we, loads[k]); end
            checks++; if (perm_cnt - b_pm !== loads[k] - 1) begin fails++; $display("FAIL exact%0d_perm_count: got %0d want %0d", lens[k], perm_cnt - b_pm, loads[k] - 1); end
            for (int i = 0; i < loads[k]; i++) begin
                checks++;
                if (bw_q[b_we + i] !== 5'd17) begin fails++; $display("FAIL exact%0d_block_words[%0d]: got %0d want 17", lens[k], i, bw_q[b_we + i]); end
            end
        end
    endtask

    task automatic test_zero_len();
        int s, b_we, b_pm, b_dn;
        b_we = we_cnt; b_pm = perm_cnt; b_dn = done_cnt;
        start_run(0, s);
        wait_done(b_dn, 20, "zero");
        repeat (3) tick();
        checks++; if (done_cyc - s !== 1) begin fails++; $display("FAIL zero_done_latency: got %0d want 1", done_cyc - s); end
        checks++; if (we_cnt - b_we !== 0) begin fails++; $display("FAIL zero_we_count: got %0d want 0", we_cnt - b_we); end
        checks++; if (perm_cnt - b_pm !== 0) begin fails++; $display("FAIL zero_perm_count: got %0d want 0", perm_cnt - b_pm); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL zero_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int s, r, b_we, b_pm, b_dn;
        b_we = we_cnt; b_pm = perm_cnt; b_dn = done_cnt;
        bus.output_buffer_available_wr = 1'b0;
        start_run(20, s);
        repeat (10) tick();
        checks++; if (we_cnt - b_we !== 0) begin fails++; $display("FAIL bp_we_while_held: got %0d want 0", we_cnt - b_we); end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL bp_busy_while_held: got %b want 1", bus.busy); end
        checks++; if (perm_cnt - b_pm !== 0 || done_cnt - b_dn !== 0) begin fails++; $display("FAIL bp_quiet_while_held: perm %0d done %0d want 0 0", perm_cnt - b_pm, done_cnt - b_dn); end
        bus.output_buffer_available_wr = 1'b1;
        r = cyc;
        wait_done(b_dn, 100, "bp");
        tick();
        checks++; if (we_cyc_q[b_we] - r !== 1) begin fails++; $display("FAIL bp_release_latency: got %0d want 1", we_cyc_q[b_we] - r); end
        checks++; if (bw_q[b_we] !== 5'd17) begin fails++; $display("FAIL bp_block_words[0]: got %0d want 17", bw_q[b_we]); end
        checks++; if (bw_q[b_we + 1] !== 5'd3) begin fails++; $display("FAIL bp_block_words[1]: got %0d want 3", bw_q[b_we + 1]); end
        checks++; if (perm_cnt - b_pm !== 1) begin fails++; $display("FAIL bp_perm_count: got %0d want 1", perm_cnt - b_pm); end
    endtask

    task automatic test_reset_midway();
        int s, b_we, b_pm, b_dn;
        resp_en = 1'b0;
        b_pm = perm_cnt; b_dn = done_cnt;
        start_run(40, s);
        for (int i = 0; i < 100 && perm_cnt == b_pm; i++) tick();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.perm_start !== 1'b0 || bus.output_buffer_we !== 1'b0 || bus.done !== 1'b0 || bus.block_words !== 5'd0) begin
            fails++; $display("FAIL midrst_outputs: ps %b we %b done %b bw %0d want all 0", bus.perm_start, bus.output_buffer_we, bus.done, bus.block_words);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (done_cnt - b_dn !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - b_dn); end
        b_pm = perm_cnt; b_we = we_cnt;
        perm_done_stray = 1'b1;
        tick();
        perm_done_stray = 1'b0;
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0 || perm_cnt != b_pm || we_cnt != b_we) begin
            fails++; $display("FAIL stray_perm_done: busy %b perm %0d we %0d want 0 0 0", bus.busy, perm_cnt - b_pm, we_cnt - b_we);
        end
        resp_en = 1'b1;
        b_dn = done_cnt;
        start_run(2, s);
        wait_done(b_dn, 50, "after_rst");
        tick();
        checks++; if (we_cnt - b_we !== 1) begin fails++; $display("FAIL after_rst_we_count: got %0d want 1", we_cnt - b_we); end
        checks++; if (bw_q[b_we] !== 5'd2) begin fails++; $display("FAIL after_rst_block_words: got %0d want 2", bw_q[b_we]); end
        checks++; if (perm_cnt - b_pm !== 0) begin fails++; $display("FAIL after_rst_perm_count: got %0d want 0", perm_cnt - b_pm); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.output_len_words = '0;
        bus.output_buffer_available_wr = 1'b0;
        test_reset();
        test_single_block();
        test_multi_block();
        test_exact_multiple();
        test_zero_len();
        test_backpressure();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
